// File: rtl/mips_pkg.sv
// mips_pkg: ALU control codes and arbiter FSM state type shared by the ALU arbiter.
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOP = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_grant.sv
// alu_rr_grant: 2-way combinational grant; round-robin on last grant, or fixed
// priority to requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_grant (
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic last,
`endif
    input  logic v0,
    input  logic v1,
    output logic g0,
    output logic g1
);

    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        g0 = v0;
`else
        // on a tie, requester 0 wins only if requester 1 was granted last
        g0 = v0 & (~v1 | last);
`endif
        g1 = v1 & ~g0;
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters (IDLE/EXEC/RESP).
// ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero
);

    state_t           state, next;
    logic [WIDTH-1:0] op_a, op_b;
    logic [2:0]       op_code;
    logic             g0, g1;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic last;
`endif

    alu_rr_grant u_grant (
`ifndef ALU_ARB_FIXED_PRIO_EN
        .last (last),
`endif
        .v0   (req0_valid),
        .v1   (req1_valid),
        .g0   (g0),
        .g1   (g1)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state == IDLE ? ((g0 | g1) ? EXEC : IDLE) :
               state == EXEC ? RESP :
               rsp_ready     ? IDLE : RESP;
    end

    always_comb begin
        req0_ready = ~reset & (state == IDLE) & g0;
        req1_ready = ~reset & (state == IDLE) & g1;
        rsp_valid  = ~reset & (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a     <= '0;
            op_b     <= '0;
            op_code  <= '0;
            rsp_id   <= 1'b0;
            rsp_y    <= '0;
            rsp_zero <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last     <= 1'b1;
`endif
        end else begin
            if (state == IDLE && (g0 | g1)) begin
                op_a    <= g1 ? req1_a : req0_a;
                op_b    <= g1 ? req1_b : req0_b;
                op_code <= g1 ? req1_op : req0_op;
                rsp_id  <= g1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                last    <= g1;
`endif
            end
            if (state == EXEC) begin
                rsp_y    <= alu_y;
                rsp_zero <= alu_zero;
            end
        end
    end

    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_ctrl = op_code;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of the ALU arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_ctrl;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_y;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_y      (alu_y),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_zero   (rsp_zero)
    );

    // external ALU sitting above the arbiter
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a | alu_b;
            3'b010:  alu_y = alu_a + alu_b;
            3'b110:  alu_y = alu_a - alu_b;
            3'b111:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = 32'd0;
        endcase
        alu_zero = alu_y == 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_id;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        step(); step();
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_y", rsp_y, 0);
        chk("rst_id", rsp_id, 0);
        req0_valid = 0; req1_valid = 0;
        step();
        reset = 1'b0;
        step();

        // req0 ADD 1+2
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 3'b010;
        #1;
        chk("add_ready0", req0_ready, 1);
        chk("add_ready1", req1_ready, 0);
        step();
        req0_valid = 0;
        #1;
        chk("add_exec_valid", rsp_valid, 0);
        chk("add_exec_ready0", req0_ready, 0);
        chk("add_alu_a", alu_a, 1);
        chk("add_alu_ctrl", alu_ctrl, 3'b010);
        step();
        chk("add_rsp_valid", rsp_valid, 1);
        chk("add_rsp_y", rsp_y, 3);
        chk("add_rsp_zero", rsp_zero, 0);
        chk("add_rsp_id", rsp_id, 0);
        step();
        chk("add_done", rsp_valid, 0);

        // req1 SUB 5-5
        req1_valid = 1; req1_a = 5; req1_b = 5; req1_op = 3'b110;
        #1;
        chk("sub_ready1", req1_ready, 1);
        step();
        req1_valid = 0;
        step();
        chk("sub_rsp_valid", rsp_valid, 1);
        chk("sub_rsp_y", rsp_y, 0);
        chk("sub_rsp_zero", rsp_zero, 1);
        chk("sub_rsp_id", rsp_id, 1);
        step();

        // tie arbitration from reset, AND op
        reset = 1;
        step();
        reset = 0;
        req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 3'b000;
        req1_a = 32'hFF; req1_b = 32'h0F; req1_op = 3'b000;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = i[0];
`endif
            chk("rr_ready0", req0_ready, !exp_id);
            chk("rr_ready1", req1_ready, exp_id);
            step(); step();
            chk("rr_rsp_id", rsp_id, exp_id);
            chk("rr_rsp_y", rsp_y, exp_id ? 32'h0F : 32'h30);
            step();
        end
        req0_valid = 0; req1_valid = 0;
        step();

        // back-pressure: OR 7|3 held for 4 cycles with rsp_ready low
        rsp_ready = 0;
        req0_valid = 1; req0_a = 7; req0_b = 3; req0_op = 3'b001;
        req1_valid = 1;
        #1;
        chk("bp_ready0", req0_ready, 1);
        step();
        req0_valid = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_y", rsp_y, 7);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_alu_a", alu_a, 7);
            chk("bp_alu_b", alu_b, 3);
            chk("bp_alu_ctrl", alu_ctrl, 3'b001);
            if (i == 2) req1_valid = 0;
            step();
        end
        chk("bp_still_valid", rsp_valid, 1);
        rsp_ready = 1;
        step();
        chk("bp_done", rsp_valid, 0);

        // unused code 101 is passed through untouched
        req1_valid = 1; req1_a = 9; req1_b = 4; req1_op = 3'b101;
        step();
        req1_valid = 0;
        #1;
        chk("op101_ctrl", alu_ctrl, 3'b101);
        step();
        chk("op101_id", rsp_id, 1);
        chk("op101_zero", rsp_zero, 1);
        step();

        // reset during EXEC discards the operation
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 3'b010;
        step();
        req0_valid = 0;
        reset = 1;
        step();
        chk("rx_valid", rsp_valid, 0);
        chk("rx_ctrl", alu_ctrl, 0);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rx_no_rsp", rsp_valid, 0);
        end
        chk("rx_y", rsp_y, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
